// File: rtl/spad_read_streamer.sv
// spad_read_streamer: burst read initiator for a synchronous-read scratchpad.
// Accepts (base, len, stride) commands, issues reads and returns the words
// as a valid/ready stream with last-word marking. A 2-entry buffer absorbs
// backpressure; reads are only issued when buffer plus in-flight space allows.
// Optional build macro: SPAD_RD_STATS_EN enables the stall_cnt statistics
// counter; without it stall_cnt is tied to zero.
module spad_read_streamer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;

  logic [WIDTH-1:0]      fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;
  logic [1:0]            count_next;
  logic [2:0]            occupancy;

  logic                  cmd_fire;
  logic                  pop;
  logic                  push;
  logic                  issue_last;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign pop        = out_valid && out_ready;
  assign push       = inflight;
  assign issue_last = (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});

  // Space already claimed by buffered words plus the read in flight, net of
  // the word leaving this cycle; a new read is allowed only below 2.
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign count_next = buf_count + {1'b0, push} - {1'b0, pop};

  assign out_valid  = (buf_count != 2'd0);
  assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last   = out_valid && fifo_last[rd_ptr];
  assign mem_r_addr = addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    mem_ren    = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_len != '0)) begin
          state_next = READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        mem_ren = (occupancy < 3'd2);
        if (mem_ren && issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((count_next == 2'd0) && !inflight) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst address/remaining counters and in-flight read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      stride        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= mem_ren;
      inflight_last <= mem_ren && issue_last;
      if (cmd_fire) begin
        addr      <= cmd_base;
        stride    <= cmd_stride;
        remaining <= cmd_len;
      end else if (mem_ren) begin
        addr      <= addr + stride;
        remaining <= remaining - {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  // Two-entry return buffer; last flag travels with each word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
      fifo_last <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_dout;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      buf_count <= count_next;
    end
  end

`ifdef SPAD_RD_STATS_EN
  // Saturating count of cycles a word waits on the consumer
  always_ff @(posedge clk) begin
    if (rst || cmd_fire) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_spad_read_streamer.sv
// Self-checking bench for spad_read_streamer (WIDTH=8, SIZE=16).
// A queue-based model predicts read addresses and stream words per command;
// a negedge compare process checks the DUT every cycle, and directed tests
// pin the model with hand-computed literals.
module tb_spad_read_streamer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SIZE  = 16;
  localparam int unsigned AW    = 4;

`ifdef SPAD_RD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_base = '0;
  logic [AW:0]      cmd_len = '0;
  logic [AW-1:0]    cmd_stride = '0;
  logic             mem_ren;
  logic [AW-1:0]    mem_r_addr;
  logic [WIDTH-1:0] mem_dout = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [15:0]      stall_cnt;

  spad_read_streamer #(
    .WIDTH(WIDTH),
    .SIZE(SIZE),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base(cmd_base),
    .cmd_len(cmd_len),
    .cmd_stride(cmd_stride),
    .mem_ren(mem_ren),
    .mem_r_addr(mem_r_addr),
    .mem_dout(mem_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Scratchpad: mem[i] = 0x10 + i, synchronous read
  logic [WIDTH-1:0] mem [SIZE];
  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(8'h10 + i);
  end
  always @(posedge clk) begin
    if (mem_ren) mem_dout <= mem[mem_r_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Model state
  logic [WIDTH-1:0] exp_data_q [$];
  logic             exp_last_q [$];
  logic [AW-1:0]    exp_addr_q [$];
  logic [WIDTH-1:0] seen_q [$];
  logic             seen_last_q [$];
  int               outstanding = 0;
  int               max_occ = 0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;
  logic             hold_last = 1'b0;
  logic [15:0]      stall_model = '0;

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int occ;
    logic popw;
    if (rst) begin
      exp_data_q.delete();
      exp_last_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      hold_prev   = 1'b0;
      stall_model = '0;
    end else begin
      popw = out_valid && out_ready;
      chk("busy", busy, exp_data_q.size() != 0);
      chk("cmd_ready", cmd_ready, exp_data_q.size() == 0);
      chk("stall_cnt", stall_cnt, STATS ? stall_model : 16'd0);
      chk("valid_has_word", !out_valid || (exp_data_q.size() != 0), 1);
      if (mem_ren) begin
        chk("ren_allowed", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("rd_addr", mem_r_addr, exp_addr_q.pop_front());
      end
      occ = outstanding - (popw ? 1 : 0) + (mem_ren ? 1 : 0);
      chk("occupancy_le2", occ <= 2, 1);
      if (occ > max_occ) max_occ = occ;
      outstanding = occ;
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", out_last, hold_last);
      end
      if (popw) begin
        if (exp_data_q.size() != 0) begin
          chk("out_data", out_data, exp_data_q.pop_front());
          chk("out_last", out_last, exp_last_q.pop_front());
        end
        seen_q.push_back(out_data);
        seen_last_q.push_back(out_last);
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (cmd_valid && cmd_ready) stall_model = '0;
      else if (out_valid && !out_ready && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
      if (cmd_valid && cmd_ready && cmd_len != '0) begin
        for (int k = 0; k < int'(cmd_len); k++) begin
          int a;
          a = (int'(cmd_base) + k * int'(cmd_stride)) % SIZE;
          exp_addr_q.push_back(4'(a));
          exp_data_q.push_back(mem[a]);
          exp_last_q.push_back(k == int'(cmd_len) - 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then run until the burst drains; out_ready is low
  // for cycles stall_lo..stall_hi counted from the handshake cycle (0)
  task automatic run_burst(input int base, input int len, input int stride,
                           input int stall_lo, input int stall_hi);
    int k;
    seen_q.delete();
    seen_last_q.delete();
    out_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_base   = 4'(base);
    cmd_len    = 5'(len);
    cmd_stride = 4'(stride);
    step();
    cmd_valid = 1'b0;
    k = 1;
    while (k < 200) begin
      out_ready = !(k >= stall_lo && k <= stall_hi);
      if (!busy && exp_data_q.size() == 0) break;
      step();
      k++;
    end
    chk("burst_done_in_time", k < 200, 1);
    out_ready = 1'b1;
  endtask

  logic [WIDTH-1:0] w [6];

  initial begin
    // Reset state
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_addr", mem_r_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // Test 1: base=2 len=4 stride=1, cycle-exact timing
    seen_q.delete();
    seen_last_q.delete();
    out_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_base   = 4'd2;
    cmd_len    = 5'd4;
    cmd_stride = 4'd1;
    chk("t1_c0_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("t1_c1_ren", mem_ren, 1);
    chk("t1_c1_addr", mem_r_addr, 2);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ready", cmd_ready, 0);
    chk("t1_c1_valid", out_valid, 0);
    step();
    chk("t1_c2_addr", mem_r_addr, 3);
    chk("t1_c2_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'h12 + i);
      chk("t1_last", out_last, i == 3);
    end
    chk("t1_c6_busy", busy, 1);
    step();
    chk("t1_c7_busy", busy, 0);
    chk("t1_c7_valid", out_valid, 0);
    chk("t1_c7_ready", cmd_ready, 1);

    // Test 2: address wrap
    run_burst(14, 4, 1, -1, -1);
    w[0] = 8'h1E; w[1] = 8'h1F; w[2] = 8'h10; w[3] = 8'h11;
    chk("t2_count", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) chk("t2_word", seen_q[i], w[i]);
    if (seen_last_q.size() == 4) chk("t2_last", seen_last_q[3], 1);

    // Test 3: stride 3
    run_burst(0, 4, 3, -1, -1);
    w[0] = 8'h10; w[1] = 8'h13; w[2] = 8'h16; w[3] = 8'h19;
    chk("t3_count", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) chk("t3_word", seen_q[i], w[i]);

    // Test 4: backpressure cycles 3..8
    max_occ = 0;
    run_burst(0, 6, 1, 3, 8);
    w[0] = 8'h10; w[1] = 8'h11; w[2] = 8'h12; w[3] = 8'h13; w[4] = 8'h14; w[5] = 8'h15;
    chk("t4_count", seen_q.size(), 6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) chk("t4_word", seen_q[i], w[i]);
    chk("t4_max_occ", max_occ, 2);
    chk("t4_stall", stall_cnt, STATS ? 16'd6 : 16'd0);

    // Test 5: zero-length command
    cmd_valid  = 1'b1;
    cmd_base   = 4'd3;
    cmd_len    = 5'd0;
    cmd_stride = 4'd1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_ready", cmd_ready, 1);
      chk("t5_busy", busy, 0);
      chk("t5_ren", mem_ren, 0);
      chk("t5_valid", out_valid, 0);
      step();
    end

    // Test 6: reset mid-burst after two words, then a fresh burst
    seen_q.delete();
    seen_last_q.delete();
    out_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_base   = 4'd0;
    cmd_len    = 5'd6;
    cmd_stride = 4'd1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t6_pre_words", seen_q.size(), 2);
    if (seen_q.size() >= 2) chk("t6_pre_word1", seen_q[1], 8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid_after_rst", out_valid, 0);
    chk("t6_ready_after_rst", cmd_ready, 1);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_ren_after_rst", mem_ren, 0);
    run_burst(5, 1, 1, -1, -1);
    chk("t6_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      chk("t6_word", seen_q[0], 8'h15);
      chk("t6_last", seen_last_q[0], 1);
    end

    step();
    chk("final_model_empty", exp_data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
